// File: rtl/event_trig_multi.sv
// Multi-channel event trigger: synchronises discriminator inputs, applies per-channel
// dead time, groups coincident edges into {mask, timestamp} words for a downstream FIFO.
module event_trig_multi #(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEAD_CYCLES  = 16,
  parameter int COINC_CYCLES = 4,
  parameter int TS_WIDTH     = 16,
  parameter int DROP_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            evnt,
  input  logic [N_CH-1:0]            chan_en,
  input  logic                       wtfull,
  output logic                       wtreq,
  output logic [N_CH+TS_WIDTH-1:0]   wtdata,
  input  logic                       drop_clr,
  output logic [DROP_WIDTH-1:0]      drop_cnt
);

  // state   | meaning
  // IDLE    | no event pending, waiting for an accepted edge
  // COLLECT | coincidence window open, accepted edges OR-ed into the mask
  // WRITE   | window closed; write the event word or count a drop on wtfull
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int CW = $clog2(COINC_CYCLES + 1);
  // The accepting cycle itself counts toward the holdoff, so the next edge
  // is accepted exactly DEAD_CYCLES cycles after the previous one.
  localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] COINC_LOAD = CW'(COINC_CYCLES - 1);

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  prev_q;
  logic [N_CH-1:0][DW-1:0]          dead_q;
  logic [TS_WIDTH-1:0]              ts_q;
  logic [N_CH-1:0]                  acc_d;

  state_t                           state_q;
  logic [N_CH-1:0]                  mask_q;
  logic [TS_WIDTH-1:0]              ts_lat_q;
  logic [CW-1:0]                    cnt_q;
  logic                             wtreq_q;
  logic [N_CH+TS_WIDTH-1:0]         wtdata_q;
  logic [DROP_WIDTH-1:0]            drop_q;

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      acc_d[i] = sync_q[SYNC_STAGES-1][i] & ~prev_q[i] & chan_en[i] & (dead_q[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      dead_q <= '0;
      ts_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], evnt};
      prev_q <= sync_q[SYNC_STAGES-1];
      ts_q   <= ts_q + 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        if (acc_d[i])
          dead_q[i] <= DEAD_LOAD;
        else if (dead_q[i] != '0)
          dead_q[i] <= dead_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      ts_lat_q <= '0;
      cnt_q    <= '0;
      wtreq_q  <= 1'b0;
      wtdata_q <= '0;
      drop_q   <= '0;
    end else begin
      wtreq_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|acc_d) begin
            mask_q   <= acc_d;
            ts_lat_q <= ts_q;
            cnt_q    <= COINC_LOAD;
            state_q  <= (COINC_CYCLES == 1) ? WRITE : COLLECT;
          end
        end
        COLLECT: begin
          mask_q <= mask_q | acc_d;
          if (cnt_q <= 1)
            state_q <= WRITE;
          else
            cnt_q <= cnt_q - 1'b1;
        end
        WRITE: begin
          if (!wtfull) begin
            wtreq_q  <= 1'b1;
            wtdata_q <= {mask_q, ts_lat_q};
          end
          // Edges landing in the write cycle start the next event rather than being lost
          if (|acc_d) begin
            mask_q   <= acc_d;
            ts_lat_q <= ts_q;
            cnt_q    <= COINC_LOAD;
            state_q  <= (COINC_CYCLES == 1) ? WRITE : COLLECT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (drop_clr)
        drop_q <= '0;
      else if (state_q == WRITE && wtfull && drop_q != '1)
        drop_q <= drop_q + 1'b1;
    end
  end

  assign wtreq    = wtreq_q;
  assign wtdata   = wtdata_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_event_trig_multi.sv
// Scoreboard bench for event_trig_multi: per-phase stimulus tables are turned into
// expected event words by a cycle-level reference model; a monitor checks each write.
module tb_event_trig_multi;
  localparam int N_CH  = 4;
  localparam int SYNC  = 2;
  localparam int DEAD  = 16;
  localparam int COINC = 4;
  localparam int TSW   = 16;
  localparam int DRW   = 8;
  localparam int MAXL  = 2600;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [N_CH-1:0]       evnt = '0;
  logic [N_CH-1:0]       chan_en = '1;
  logic                  wtfull = 1'b0;
  logic                  drop_clr = 1'b0;
  logic                  wtreq;
  logic [N_CH+TSW-1:0]   wtdata;
  logic [DRW-1:0]        drop_cnt;

  event_trig_multi #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEAD_CYCLES(DEAD),
    .COINC_CYCLES(COINC), .TS_WIDTH(TSW), .DROP_WIDTH(DRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .evnt(evnt), .chan_en(chan_en), .wtfull(wtfull),
    .wtreq(wtreq), .wtdata(wtdata), .drop_clr(drop_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint              stamp;
    logic [N_CH+TSW-1:0] word;
  } exp_t;

  int n_pass = 0;
  int n_total = 0;
  longint g = 0;
  logic [TSW-1:0] tsm;
  exp_t sb[$];
  exp_t e;
  logic [N_CH+TSW-1:0] last_word = '0;
  logic [N_CH+TSW-1:0] prev_word = '0;
  int n_writes = 0;
  int exp_drop = 0;

  logic [N_CH-1:0] lvl [MAXL+8];
  bit              wtf [MAXL+8];
  logic [N_CH-1:0] acc [MAXL+8];

  always @(posedge clk) g <= g + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tsm <= '0;
    else        tsm <= tsm + 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && wtreq) begin
      n_writes++;
      prev_word = last_word;
      last_word = wtdata;
      if (sb.size() == 0) begin
        chk("unexpected_wtreq", wtreq, 0);
      end else begin
        e = sb.pop_front();
        chk("wtdata", wtdata, e.word);
        chk("wtreq_cycle", g, e.stamp);
      end
    end
  end

  task automatic clear_arrays();
    for (int p = 0; p < MAXL + 8; p++) begin
      lvl[p] = '0;
      wtf[p] = 1'b0;
    end
  endtask

  task automatic pulse(input int ch, input int q, input int w);
    for (int j = 0; j < w; j++) lvl[q+j][ch] = 1'b1;
  endtask

  // Caller is positioned just after a negedge; stimulus must leave a quiet tail of 48 cycles.
  task automatic run_phase(input int len);
    longint g0;
    int ts0, t, w;
    int last [N_CH];
    logic [N_CH-1:0] m;
    bit rise;
    g0  = g;
    ts0 = int'(tsm);
    for (int i = 0; i < N_CH; i++) last[i] = -1000;
    for (int ec = 0; ec < len + COINC + 3; ec++) begin
      acc[ec] = '0;
      for (int i = 0; i < N_CH; i++) begin
        int q;
        q = ec - SYNC;
        if (q >= 0 && q < len) begin
          rise = lvl[q][i] && (q == 0 || !lvl[q-1][i]);
          if (rise && chan_en[i] && (ec - last[i] >= DEAD)) begin
            acc[ec][i] = 1'b1;
            last[i] = ec;
          end
        end
      end
    end
    t = 0;
    while (t < len) begin
      if (acc[t] != '0) begin
        m = acc[t];
        for (int j = 1; j < COINC; j++) m |= acc[t+j];
        w = t + COINC;
        if (!wtf[w]) sb.push_back('{stamp: g0 + w + 1, word: {m, TSW'(ts0 + t)}});
        else if (exp_drop < (1 << DRW) - 1) exp_drop++;
        t = w;
      end else begin
        t++;
      end
    end
    for (int p = 0; p < len; p++) begin
      evnt   = lvl[p];
      wtfull = wtf[p];
      @(negedge clk);
    end
    evnt   = '0;
    wtfull = 1'b0;
    chk("sb_drained", sb.size(), 0);
    chk("drop_cnt", drop_cnt, exp_drop);
  endtask

  initial begin
    #15_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin
    int w0, q, len, guard;
    logic [N_CH-1:0] cur;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wtreq", wtreq, 0);
    chk("rst_wtdata", wtdata, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single edge on channel 2 with timestamp 0x0100 at the accepted-edge cycle
    clear_arrays();
    q = 16'h0100 - int'(tsm) - SYNC;
    pulse(2, q, 3);
    w0 = n_writes;
    run_phase(q + 60);
    chk("single_writes", n_writes - w0, 1);
    chk("single_word", last_word, {4'b0100, 16'h0100});

    // coincidence inside the window, then just outside it
    clear_arrays();
    pulse(0, 10, 3);
    pulse(3, 13, 3);
    w0 = n_writes;
    run_phase(80);
    chk("coinc_writes", n_writes - w0, 1);
    chk("coinc_mask", last_word[N_CH+TSW-1:TSW], 4'b1001);

    clear_arrays();
    pulse(0, 10, 3);
    pulse(1, 14, 3);
    w0 = n_writes;
    run_phase(80);
    chk("split_writes", n_writes - w0, 2);
    chk("split_mask1", prev_word[N_CH+TSW-1:TSW], 4'b0001);
    chk("split_mask2", last_word[N_CH+TSW-1:TSW], 4'b0010);

    // dead time: channel 1 toggling every 4 cycles
    clear_arrays();
    for (int j = 0; j < 40; j++) lvl[10+j][1] = ((j / 4) % 2 == 0);
    w0 = n_writes;
    run_phase(120);
    chk("dead_writes", n_writes - w0, 3);

    // FIFO full for 300 events, then clear the drop counter
    clear_arrays();
    for (int k = 0; k < 300; k++) pulse(k % N_CH, 20 + 8 * k, 2);
    len = 20 + 8 * 300 + 60;
    for (int p = 0; p < len; p++) wtf[p] = 1'b1;
    w0 = n_writes;
    run_phase(len);
    chk("full_writes", n_writes - w0, 0);
    chk("drop_sat", drop_cnt, 8'hFF);
    drop_clr = 1'b1;
    @(negedge clk);
    drop_clr = 1'b0;
    exp_drop = 0;
    chk("drop_clr", drop_cnt, 0);

    // reset while collecting discards the pending event
    w0 = n_writes;
    evnt = 4'b0100;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    evnt  = '0;
    exp_drop = 0;
    #1;
    chk("midrst_wtreq", wtreq, 0);
    chk("midrst_wtdata", wtdata, 0);
    chk("midrst_drop", drop_cnt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_nowrite", n_writes - w0, 0);
    chk("midrst_wtdata_after", wtdata, 0);
    clear_arrays();
    pulse(1, 5, 2);
    w0 = n_writes;
    run_phase(60);
    chk("postrst_writes", n_writes - w0, 1);

    // disabled channel never produces an event
    chan_en = 4'b1011;
    clear_arrays();
    pulse(2, 5, 3);
    pulse(0, 30, 2);
    w0 = n_writes;
    run_phase(90);
    chk("en_writes", n_writes - w0, 1);
    chk("en_mask", last_word[N_CH+TSW-1:TSW], 4'b0001);
    chan_en = '1;

    // randomized phases with random enables and backpressure
    for (int r = 0; r < 6; r++) begin
      clear_arrays();
      chan_en = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      cur = '0;
      for (int p = 0; p < 500 - 48; p++) begin
        for (int i = 0; i < N_CH; i++) if ($urandom % 6 == 0) cur[i] = ~cur[i];
        lvl[p] = cur;
      end
      for (int p = 0; p < 500; p++) wtf[p] = ($urandom % 4 == 0);
      run_phase(500);
    end
    chan_en = '1;

    // timestamp wrap: event at 0xFFFF, follow-up event in the write cycle
    guard = 0;
    while (tsm != 16'hFFC0 && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    clear_arrays();
    q = 16'hFFFF - int'(tsm) - SYNC;
    pulse(0, q, 2);
    pulse(1, q + COINC, 2);
    run_phase(q + 70);
    chk("wrap_ts_ffff", prev_word[TSW-1:0], 16'hFFFF);
    chk("wrap_ts_next", last_word[TSW-1:0], 16'h0003);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
